// File: rtl/x8_seq_mul_ctrl.sv
// ---------------------------------------------------------------------------
// x8_seq_mul_ctrl : sequential shift-add 8x8 unsigned multiplier
//
// This multiplier needs eight additions. It reuses one 8-bit adder
// (x8_approx_add) for all of them, doing one multiplier bit per clock. The N4
// parameter is passed to the adder. It sets how many low-order adder cells are
// approximate (0 = exact).
//
// Ports
//   clk        in   1   system clock, rising edge
//   rst        in   1   asynchronous active-high reset
//   in_valid   in   1   operand pair valid
//   in_ready   out  1   operands accepted (high only in IDLE)
//   a          in   8   multiplicand, unsigned
//   b          in   8   multiplier, unsigned
//   out_valid  out  1   product valid (high only in DONE)
//   out_ready  in   1   consumer accepts product
//   product    out  16  result {hi, lo}; holds last result, 0 after reset
//   busy       out  1   high in RUN or DONE
//
// Build option
//   ZERO_SKIP_EN : when defined, a zero operand jumps straight from IDLE to
//                  DONE with product 0, and the adder is never stepped.
// ---------------------------------------------------------------------------

// Exact full-adder cell.
module x1_accu_add (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);
  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

// Approximate cell. The sum still uses the incoming carry. The outgoing carry
// comes only from the generate term (a & b), so the carry never ripples
// through a chain of approximate cells.
module x1_approx_add (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);
  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = i_a & i_b;
endmodule

// 8-bit adder. Bits [N4-1:0] use approximate cells; the bits above use exact
// cells.
module x8_approx_add #(
  parameter int N4 = 0
) (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic       i_cin_8bit,
  output logic [7:0] o_sum,
  output logic       o_cout
);
  logic [8:0] w_c;

  assign w_c[0] = i_cin_8bit;

  for (genvar gi = 0; gi < 8; gi++) begin : g_cell
    if (gi < N4) begin : g_apx
      x1_approx_add u_cell (
        .i_a    (i_a[gi]),
        .i_b    (i_b[gi]),
        .i_cin  (w_c[gi]),
        .o_sum  (o_sum[gi]),
        .o_cout (w_c[gi+1])
      );
    end else begin : g_acc
      x1_accu_add u_cell (
        .i_a    (i_a[gi]),
        .i_b    (i_b[gi]),
        .i_cin  (w_c[gi]),
        .o_sum  (o_sum[gi]),
        .o_cout (w_c[gi+1])
      );
    end
  end

  assign o_cout = w_c[8];
endmodule

module x8_seq_mul_ctrl #(
  parameter int N4 = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] product,
  output logic        busy
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [7:0]  r_mcand;
  logic [7:0]  r_hi;
  logic [7:0]  r_lo;
  logic [2:0]  r_cnt;
  logic [15:0] r_product;

  logic [7:0]  w_sum;
  logic        w_cout;
  logic [7:0]  w_hi_step;
  logic [7:0]  w_lo_step;
  logic        w_zero_op;

  x8_approx_add #(.N4(N4)) u_add (
    .i_a        (r_hi),
    .i_b        (r_mcand),
    .i_cin_8bit (1'b0),
    .o_sum      (w_sum),
    .o_cout     (w_cout)
  );

`ifdef ZERO_SKIP_EN
  assign w_zero_op = (a == 8'd0) || (b == 8'd0);
`else
  assign w_zero_op = 1'b0;
`endif

  // One shift-add step. The adder carry becomes the new top bit of hi. The
  // bit shifted out of hi moves into the top of lo, which drops the multiplier
  // bit it has just used.
  always_comb begin
    w_hi_step = 8'd0;
    w_lo_step = 8'd0;
    if (r_lo[0]) begin
      {w_hi_step, w_lo_step} = {w_cout, w_sum, r_lo[7:1]};
    end else begin
      {w_hi_step, w_lo_step} = {1'b0, r_hi, r_lo[7:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_nxt = w_zero_op ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (r_cnt == 3'd7) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        // in_valid is not looked at here. A new pair can be accepted only
        // after the return to IDLE.
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // r_product is loaded only on entry to DONE. That way the output shows
  // {hi,lo} while in DONE and holds the last result through IDLE and RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand   <= 8'd0;
      r_hi      <= 8'd0;
      r_lo      <= 8'd0;
      r_cnt     <= 3'd0;
      r_product <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_mcand <= a;
            r_hi    <= 8'd0;
            r_cnt   <= 3'd0;
            if (w_zero_op) begin
              r_lo      <= 8'd0;
              r_product <= 16'd0;
            end else begin
              r_lo <= b;
            end
          end
        end
        S_RUN: begin
          r_hi  <= w_hi_step;
          r_lo  <= w_lo_step;
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == 3'd7) begin
            r_product <= {w_hi_step, w_lo_step};
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign product = r_product;

endmodule

// File: tb/tb_x8_seq_mul_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for x8_seq_mul_ctrl. Two instances run side by side on the same
// stimulus: one exact (N4=0) and one with four approximate cells (N4=4). A
// transaction-level model predicts every output on every cycle. The model
// computes each product with plain integer arithmetic, one multiplier bit at
// a time.
// ---------------------------------------------------------------------------
module tb_x8_seq_mul_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  a = 8'd0;
  logic [7:0]  b = 8'd0;

  logic        in_ready0, out_valid0, busy0;
  logic        in_ready4, out_valid4, busy4;
  logic [15:0] product0, product4;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  x8_seq_mul_ctrl #(.N4(0)) u_dut0 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready0),
    .a         (a),
    .b         (b),
    .out_valid (out_valid0),
    .out_ready (out_ready),
    .product   (product0),
    .busy      (busy0)
  );

  x8_seq_mul_ctrl #(.N4(4)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready4),
    .a         (a),
    .b         (b),
    .out_valid (out_valid4),
    .out_ready (out_ready),
    .product   (product4),
    .busy      (busy4)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Adder with n4 approximate low bits. In that region each sum bit is
  // x^y^(generate of the bit below), with 0 below bit 0. The bits above are
  // added exactly. Their carry-in is the generate of bit n4-1.
  function automatic int approx_add(input int x, input int y, input int n4);
    int t, c, hi, mask;
    mask = (1 << n4) - 1;
    t    = x ^ y ^ ((x & y) << 1);
    c    = (n4 > 0) ? (((x & y) >> (n4 - 1)) & 1) : 0;
    hi   = (x >> n4) + (y >> n4) + c;
    return (hi << n4) | (t & mask);
  endfunction

  function automatic int mul_model(input int x, input int y, input int n4);
    int hi, lo, s;
    hi = 0;
    lo = y;
    for (int i = 0; i < 8; i++) begin
      s  = ((lo & 1) != 0) ? approx_add(hi, x, n4) : hi;
      lo = ((s & 1) << 7) | (lo >> 1);
      hi = s >> 1;
    end
    return (hi << 8) | lo;
  endfunction

  // Model state. m_busy marks an accepted transaction. m_left counts the
  // steps still to run. The transaction is in DONE when m_busy is set and
  // m_left is 0.
  bit m_busy = 1'b0;
  int m_left = 0;
  int m_exp0 = 0, m_exp4 = 0;
  int m_prod0 = 0, m_prod4 = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy  = 1'b0;
      m_left  = 0;
      m_prod0 = 0;
      m_prod4 = 0;
    end else if (!m_busy) begin
      if (in_valid) begin
        bit zs;
        zs = 1'b0;
`ifdef ZERO_SKIP_EN
        zs = (a == 8'd0) || (b == 8'd0);
`endif
        m_busy = 1'b1;
        m_exp0 = mul_model(int'(a), int'(b), 0);
        m_exp4 = mul_model(int'(a), int'(b), 4);
        if (zs) begin
          m_left  = 0;
          m_prod0 = 0;
          m_prod4 = 0;
        end else begin
          m_left = 8;
        end
      end
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_prod0 = m_exp0;
        m_prod4 = m_exp4;
      end
    end else if (out_ready) begin
      m_busy = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("in_ready_n0",  32'(in_ready0),  32'(!m_busy));
      chk("out_valid_n0", 32'(out_valid0), 32'(m_busy && m_left == 0));
      chk("busy_n0",      32'(busy0),      32'(m_busy));
      chk("product_n0",   32'(product0),   m_prod0);
      chk("in_ready_n4",  32'(in_ready4),  32'(!m_busy));
      chk("out_valid_n4", 32'(out_valid4), 32'(m_busy && m_left == 0));
      chk("busy_n4",      32'(busy4),      32'(m_busy));
      chk("product_n4",   32'(product4),   m_prod4);
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready0),  32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid0), 32'd0);
    chk({tag, "_busy"},      32'(busy0),      32'd0);
    chk({tag, "_product"},   32'(product0),   32'd0);
    chk({tag, "_in_ready4"}, 32'(in_ready4),  32'd1);
    chk({tag, "_product4"},  32'(product4),   32'd0);
  endtask

  // One directed transaction. exp_lat counts clock edges after the accept
  // edge until out_valid is seen. A zero-skip operand goes to DONE on the
  // accept edge itself, so its expected value is 0.
  task automatic run_txn(input logic [7:0] ta, input logic [7:0] tb_, input int hold,
                         input logic [15:0] exp_p, input int exp_lat, input string tag);
    int k;
    k = 0;
    while (!in_ready0 && k < 30) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_idle_ready"}, 32'(in_ready0), 32'd1);
    in_valid  = 1'b1;
    a         = ta;
    b         = tb_;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    a        = 8'($urandom);
    b        = 8'($urandom);
    k = 0;
    while (!out_valid0 && k < 30) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_latency"}, 32'(k), 32'(exp_lat));
    chk({tag, "_product"}, 32'(product0), 32'(exp_p));
    // While the product is stalled, offer a new pair. It must be ignored.
    in_valid = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, "_hold_product"}, 32'(product0),   32'(exp_p));
      chk({tag, "_hold_valid"},   32'(out_valid0), 32'd1);
      chk({tag, "_hold_ready"},   32'(in_ready0),  32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_back_idle"},   32'(in_ready0),  32'd1);
    chk({tag, "_valid_drop"},  32'(out_valid0), 32'd0);
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    int zs_lat;
`ifdef ZERO_SKIP_EN
    zs_lat = 0;
`else
    zs_lat = 8;
`endif

    // Pin the reference model with hand-computed values.
    chk("model_13x11",   32'(mul_model(13, 11, 0)),    32'h008F);
    chk("model_FFxFF",   32'(mul_model(255, 255, 0)),  32'hFE01);
    chk("model_A5x3C",   32'(mul_model(165, 60, 0)),   32'h26AC);
    chk("model_apx_0F1", 32'(approx_add(15, 1, 4)),    32'h00C);
    chk("model_apx_888", 32'(approx_add(136, 136, 4)), 32'h110);

    #1 rst = 1'b1;
    #1 chk_reset_outputs("rst_init");
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst_held");
    #2 rst = 1'b0;
    chk_en = 1'b1;

    run_txn(8'd13,  8'd11,  0, 16'h008F, 8, "t13x11");
    run_txn(8'hFF,  8'hFF,  0, 16'hFE01, 8, "tFFxFF");
    run_txn(8'hA5,  8'h3C,  5, 16'h26AC, 8, "tA5x3C");

    // Reset while in RUN with cnt=3. The outputs clear at once, without a clock.
    in_valid = 1'b1;
    a = 8'h55;
    b = 8'h99;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("rst_mid_run");
    @(negedge clk);
    #2 rst = 1'b0;
    run_txn(8'd2, 8'd3, 0, 16'h0006, 8, "t2x3");

    run_txn(8'd0, 8'h77, 0, 16'h0000, zs_lat, "t0x77");

    // Random traffic with random backpressure. Zero operands appear often.
    for (int t = 0; t < 30000; t++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
      b         = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (12) @(negedge clk);
    chk("drain_idle", 32'(in_ready0), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
